// File: rtl/frame_bank_pkg.sv
// Shared types and constants for the triple-buffer frame bank scheduler.
// Bank indices, reset roles and the write/read FSM encodings live here.
package frame_bank_pkg;

   typedef logic [1:0] bank_t;

   localparam bank_t WR_BANK_RST  = 2'd0;
   localparam bank_t RDY_BANK_RST = 2'd1;
   localparam bank_t RD_BANK_RST  = 2'd2;

   localparam int FRAME_WORDS_DEF = 307200;
   localparam int WORD_CNT_W      = 19;

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_REQ    = 2'd1,
      W_ACTIVE = 2'd2
   } wr_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_REQ  = 1'b1
   } rd_state_t;

endpackage

// File: rtl/bank_rotator.sv
// Holds the write/ready/display bank roles, the ready flag and the drop counter.
// A completed frame and a display vsync rotate the roles so the three banks stay a permutation.
module bank_rotator
   import frame_bank_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        complete,
   input  logic        vsync,
   output bank_t       wr_bank,
   output bank_t       rd_bank,
   output bank_t       wr_bank_nxt,
   output bank_t       rd_bank_nxt,
   output logic [15:0] frames_dropped
);

   bank_t       ready_bank;
   bank_t       ready_bank_nxt;
   logic        ready_valid;
   logic        ready_valid_nxt;
   logic [15:0] drop_cnt;
   logic [15:0] drop_nxt;

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      wr_bank_nxt     = wr_bank;
      rd_bank_nxt     = rd_bank;
      ready_bank_nxt  = ready_bank;
      ready_valid_nxt = ready_valid;
      drop_nxt        = drop_cnt;

      if (complete && ready_valid && (drop_cnt != 16'hFFFF))
         drop_nxt = drop_cnt + 16'd1;

      if (complete && vsync) begin
         // The just-finished frame goes straight to display; the old display bank becomes spare.
         rd_bank_nxt     = wr_bank;
         wr_bank_nxt     = ready_bank;
         ready_bank_nxt  = rd_bank;
         ready_valid_nxt = 1'b0;
      end else if (complete) begin
         wr_bank_nxt     = ready_bank;
         ready_bank_nxt  = wr_bank;
         ready_valid_nxt = 1'b1;
      end else if (vsync && ready_valid) begin
         rd_bank_nxt     = ready_bank;
         ready_bank_nxt  = rd_bank;
         ready_valid_nxt = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_bank     <= WR_BANK_RST;
         ready_bank  <= RDY_BANK_RST;
         rd_bank     <= RD_BANK_RST;
         ready_valid <= 1'b0;
         drop_cnt    <= 16'd0;
      end else begin
         wr_bank     <= wr_bank_nxt;
         ready_bank  <= ready_bank_nxt;
         rd_bank     <= rd_bank_nxt;
         ready_valid <= ready_valid_nxt;
         drop_cnt    <= drop_nxt;
      end
   end

   assign frames_dropped = drop_cnt;

endmodule

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer scheduler: forwards pixel-writer frame requests to SDRAM, counts words to
// detect completion, and issues display read requests against the newest complete bank.
module frame_bank_scheduler
   import frame_bank_pkg::*;
#(
   parameter int                FRAME_WORDS = FRAME_WORDS_DEF,
   parameter int                ADDR_W      = 24,
   parameter logic [ADDR_W-1:0] BANK_STRIDE = 24'h080000
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_req_in,
   output logic              wr_ack_out,
   input  logic              wr_en_mon,
   output logic              sdram_wr_req,
   input  logic              sdram_wr_ack,
   output logic [ADDR_W-1:0] sdram_wr_addr,
   input  logic              rd_vsync,
   output logic              sdram_rd_req,
   input  logic              sdram_rd_ack,
   output logic [ADDR_W-1:0] sdram_rd_addr,
   output bank_t             wr_bank,
   output bank_t             rd_bank,
   output logic [15:0]       frames_dropped,
   output logic              err_stray_wr
);

   localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(FRAME_WORDS - 1);

   wr_state_t             wr_state;
   wr_state_t             wr_state_nxt;
   rd_state_t             rd_state;
   rd_state_t             rd_state_nxt;
   logic [WORD_CNT_W-1:0] word_cnt;
   logic                  cnt_clr;
   logic                  cnt_inc;
   logic                  frame_done;
   logic                  stray;
   bank_t                 wr_bank_nxt;
   bank_t                 rd_bank_nxt;

   function automatic logic [ADDR_W-1:0] bank_base(input bank_t b);
      return ADDR_W'(b) * BANK_STRIDE;
   endfunction

   bank_rotator u_rotator (
      .clk            (clk),
      .reset          (reset),
      .complete       (frame_done),
      .vsync          (rd_vsync),
      .wr_bank        (wr_bank),
      .rd_bank        (rd_bank),
      .wr_bank_nxt    (wr_bank_nxt),
      .rd_bank_nxt    (rd_bank_nxt),
      .frames_dropped (frames_dropped)
   );

   // Write FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) wr_state <= W_IDLE;
      else       wr_state <= wr_state_nxt;
   end

   always_comb begin
      wr_state_nxt = wr_state;
      case (wr_state)
         W_IDLE:   if (wr_req_in)    wr_state_nxt = W_REQ;
         W_REQ:    if (sdram_wr_ack) wr_state_nxt = W_ACTIVE;
         W_ACTIVE: if (frame_done)   wr_state_nxt = W_IDLE;
         default:                    wr_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      sdram_wr_req = 1'b0;
      wr_ack_out   = 1'b0;
      cnt_clr      = 1'b0;
      cnt_inc      = 1'b0;
      frame_done   = 1'b0;
      stray        = 1'b0;
      case (wr_state)
         W_IDLE: stray = wr_en_mon;
         W_REQ: begin
            sdram_wr_req = 1'b1;
            wr_ack_out   = sdram_wr_ack;
            cnt_clr      = sdram_wr_ack;
            stray        = wr_en_mon;
         end
         W_ACTIVE: begin
            cnt_inc    = wr_en_mon;
            frame_done = wr_en_mon && (word_cnt == LAST_WORD);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        word_cnt <= '0;
      else if (cnt_clr) word_cnt <= '0;
      else if (cnt_inc) word_cnt <= word_cnt + WORD_CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      err_stray_wr <= 1'b0;
      else if (stray) err_stray_wr <= 1'b1;
   end

   // Read FSM: a vsync during an outstanding request is absorbed, only the address moves.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rd_state <= R_IDLE;
      else       rd_state <= rd_state_nxt;
   end

   always_comb begin
      rd_state_nxt = rd_state;
      case (rd_state)
         R_IDLE:  if (rd_vsync)     rd_state_nxt = R_REQ;
         R_REQ:   if (sdram_rd_ack) rd_state_nxt = R_IDLE;
         default:                   rd_state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      sdram_rd_req = (rd_state == R_REQ);
   end

   // Addresses are registered from the next bank values so they move in step with the banks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sdram_wr_addr <= bank_base(WR_BANK_RST);
         sdram_rd_addr <= bank_base(RD_BANK_RST);
      end else begin
         sdram_wr_addr <= bank_base(wr_bank_nxt);
         sdram_rd_addr <= bank_base(rd_bank_nxt);
      end
   end

endmodule

// File: doc/frame_bank_scheduler.md
Name: frame_bank_scheduler

Overview:
- Triple-buffer bank scheduler between the UDP-to-SDRAM pixel writer, the display read path and the frame_read_write SDRAM port.
- Owns three SDRAM frame banks with fixed roles: write, ready and display.
- Forwards the writer's frame request to SDRAM with the write-bank base address and counts written words to detect frame completion.
- Rotates banks so the display always reads the newest complete frame without tearing.

Parameters:
FRAME_WORDS, 307200, 32-bit words per frame (640*480)
BANK_STRIDE, 24'h080000, word-address distance between bank bases (must be >= FRAME_WORDS)
ADDR_W, 24, SDRAM word-address width

Ports:
clk  in  1  system clock (udp_clk domain)
reset  in  1  reset
wr_req_in  in  1  frame write request from pixel writer, level, held until wr_ack_out
wr_ack_out  out  1  one-cycle ack to pixel writer
wr_en_mon  in  1  writer's per-word write strobe, monitored only
sdram_wr_req  out  1  write-frame request to frame_read_write
sdram_wr_ack  in  1  write-frame ack from frame_read_write
sdram_wr_addr  out  ADDR_W  write-frame base address
rd_vsync  in  1  one-cycle pulse at display frame start (already in clk domain)
sdram_rd_req  out  1  read-frame request
sdram_rd_ack  in  1  read-frame ack
sdram_rd_addr  out  ADDR_W  read-frame base address
wr_bank  out  2  bank being written
rd_bank  out  2  bank being displayed
frames_dropped  out  16  saturating count of completed frames overwritten before display
err_stray_wr  out  1  sticky: wr_en_mon seen outside W_ACTIVE

Behaviour:
- Reset is asynchronous and active-high. Reset values: wr_bank=0, ready_bank=1, rd_bank=2, ready_valid=0. All req/ack outputs are 0. frames_dropped=0. err_stray_wr=0. Both FSMs go to IDLE. A reset mid-frame abandons the frame; no partial frame ever becomes ready.
- Addresses: sdram_wr_addr = wr_bank*BANK_STRIDE and sdram_rd_addr = rd_bank*BANK_STRIDE. Both are registered and update with the bank registers.
- Write FSM:
  - W_IDLE: when wr_req_in=1, go to W_REQ and assert sdram_wr_req next cycle.
  - W_REQ: hold sdram_wr_req until sdram_wr_ack=1. In the ack cycle, pulse wr_ack_out for one cycle, drop sdram_wr_req, clear word_cnt (19 bit), go to W_ACTIVE. Total latency from wr_req_in to wr_ack_out is 1 cycle plus the SDRAM ack latency.
  - W_ACTIVE: each wr_en_mon=1 increments word_cnt. On the strobe where word_cnt==FRAME_WORDS-1, the frame is complete: go to W_IDLE and perform the rotation below. wr_req_in is ignored while in W_ACTIVE.
- wr_en_mon=1 in W_IDLE or W_REQ sets err_stray_wr, which stays set until reset. The strobe is not counted.
- Frame completion, no vsync in the same cycle: swap wr_bank and ready_bank, then set ready_valid=1. If ready_valid was already 1, increment frames_dropped, saturating at 16'hFFFF.
- rd_vsync, no completion in the same cycle: if ready_valid=1, swap rd_bank and ready_bank and clear ready_valid. Otherwise rd_bank is unchanged and the same frame repeats.
- Completion and rd_vsync in the same cycle: new rd_bank = old wr_bank, new wr_bank = old ready_bank, new ready_bank = old rd_bank, ready_valid=0. frames_dropped increments if the old ready_valid was 1.
- Invariant: the three bank registers are always a permutation of {0,1,2}.
- Read FSM:
  - R_IDLE: rd_vsync moves to R_REQ. sdram_rd_req asserts the cycle after the pulse, with sdram_rd_addr already showing the post-rotation rd_bank.
  - R_REQ: hold until sdram_rd_ack, then drop the request and return to R_IDLE.
  - An rd_vsync while in R_REQ performs the bank rotation, and sdram_rd_addr updates to the new rd_bank. A second request is not queued; the outstanding request is served with the new address.
- The two FSMs are independent. A write in progress never blocks a display rotation, and vice versa.

Decomposition:
- frame_bank_pkg: bank-index type (2 bit), reset bank constants (0/1/2), write-FSM and read-FSM state encodings, FRAME_WORDS default.
- One sub-module, bank_rotator: holds the three bank registers, ready_valid and frames_dropped. Its inputs are complete and vsync; its outputs are the bank indices. The two FSMs and the address generation stay in the top level.

Test Plan:
- Reset, then rd_vsync with no frame written -> sdram_rd_req=1 next cycle, sdram_rd_addr=2*BANK_STRIDE, rd_bank=2, frames_dropped=0.
- wr_req_in held, sdram_wr_ack after 5 cycles -> sdram_wr_addr=0, one-cycle wr_ack_out, then FRAME_WORDS=16 strobes (bench override) -> wr_bank=1, ready_valid=1. Next rd_vsync -> rd_bank=0, ready_bank=2.
- Two frames completed with no vsync in between -> frames_dropped=1, wr_bank returns to 0 after the second frame, and the next vsync selects bank 1.
- Completion strobe and rd_vsync in the same cycle (start wr=0, rdy=1, rd=2) -> rd=0, wr=1, rdy=2, ready_valid=0.
- wr_en_mon pulsed in W_IDLE -> err_stray_wr=1 and sticky, word count unaffected. Reset asserted mid-frame (word 7) -> wr_bank=0, no ready frame, FSMs idle, err_stray_wr=0.
- Bank permutation assertion checked every cycle through a randomized 10k-cycle run of writes and vsyncs, and frames_dropped checked for saturation by forcing the counter to 16'hFFFE.
